// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the ID-stage control slice:
//   - opcode constants (OP_*) and ALU commands (EXE_*)
//   - branch/compare conditions (COND_*)
//   - MULT/DIV sequencer state enum
//   - ctrl_bundle_t, the control bundle handed to the ID/EX register
package ctrl_pkg;

  localparam int OP_W  = 6;
  localparam int EXE_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd3;
  localparam logic [OP_W-1:0] OP_AND  = 6'd5;
  localparam logic [OP_W-1:0] OP_OR   = 6'd6;
  localparam logic [OP_W-1:0] OP_NOR  = 6'd7;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd8;
  localparam logic [OP_W-1:0] OP_SLA  = 6'd9;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd10;
  localparam logic [OP_W-1:0] OP_SRA  = 6'd11;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd12;
  localparam logic [OP_W-1:0] OP_SLT  = 6'd13;
  localparam logic [OP_W-1:0] OP_SLTU = 6'd14;
  localparam logic [OP_W-1:0] OP_MULT = 6'd16;
  localparam logic [OP_W-1:0] OP_DIV  = 6'd17;
  localparam logic [OP_W-1:0] OP_MFHI = 6'd18;
  localparam logic [OP_W-1:0] OP_MFLO = 6'd19;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd32;
  localparam logic [OP_W-1:0] OP_SUBI = 6'd33;
  localparam logic [OP_W-1:0] OP_ANDI = 6'd34;
  localparam logic [OP_W-1:0] OP_ORI  = 6'd35;
  localparam logic [OP_W-1:0] OP_LD   = 6'd36;
  localparam logic [OP_W-1:0] OP_ST   = 6'd37;
  localparam logic [OP_W-1:0] OP_XORI = 6'd38;
  localparam logic [OP_W-1:0] OP_SLTI = 6'd39;
  localparam logic [OP_W-1:0] OP_BEZ  = 6'd40;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd41;
  localparam logic [OP_W-1:0] OP_JMP  = 6'd42;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd43;

  // Arithmetic and logical left shifts are the same operation, so they share a command.
  localparam logic [EXE_W-1:0] EXE_ADD  = 4'd0;
  localparam logic [EXE_W-1:0] EXE_MFLO = 4'd1;
  localparam logic [EXE_W-1:0] EXE_SUB  = 4'd2;
  localparam logic [EXE_W-1:0] EXE_MFHI = 4'd3;
  localparam logic [EXE_W-1:0] EXE_AND  = 4'd4;
  localparam logic [EXE_W-1:0] EXE_OR   = 4'd5;
  localparam logic [EXE_W-1:0] EXE_NOR  = 4'd6;
  localparam logic [EXE_W-1:0] EXE_XOR  = 4'd7;
  localparam logic [EXE_W-1:0] EXE_SLA  = 4'd8;
  localparam logic [EXE_W-1:0] EXE_SLL  = 4'd8;
  localparam logic [EXE_W-1:0] EXE_SRA  = 4'd9;
  localparam logic [EXE_W-1:0] EXE_SRL  = 4'd10;
  localparam logic [EXE_W-1:0] EXE_SLT  = 4'd11;
  localparam logic [EXE_W-1:0] EXE_SLTU = 4'd12;
  localparam logic [EXE_W-1:0] EXE_MULT = 4'd13;
  localparam logic [EXE_W-1:0] EXE_DIV  = 4'd14;

  localparam logic [3:0] COND_NONE = 4'd0;
  localparam logic [3:0] COND_JUMP = 4'd1;
  localparam logic [3:0] COND_BEZ  = 4'd2;
  localparam logic [3:0] COND_BNE  = 4'd3;
  localparam logic [3:0] COND_BEQ  = 4'd4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    logic             branchEn;
    logic [EXE_W-1:0] EXE_CMD;
    logic [3:0]       Branch_command;
    logic             Is_Imm;
    logic             ST_or_BNE;
    logic             WB_EN;
    logic             MEM_R_EN;
    logic             MEM_W_EN;
    logic             illegal_op;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder
// Purely combinational opcode -> control bundle map.
// Configuration: CTRL_MULDIV_EN enables decode of MULT/DIV/MFHI/MFLO;
// without it those opcodes decode as illegal.
// Ports:
//   op_code  in   OP_CODE_LEN  ID-stage opcode
//   bundle   out  ctrl_bundle_t decoded controls (illegal_op=1 for unknown opcodes)
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int OP_CODE_LEN = 6
) (
  input  logic [OP_CODE_LEN-1:0] op_code,
  output ctrl_bundle_t           bundle
);

  logic [OP_W-1:0] op;
  logic            in_range;

  // Opcode table. Wider opcode buses are only legal when the extra upper bits are zero.
  always_comb begin
    op       = OP_W'(op_code);
    in_range = ((op_code >> OP_W) == '0);
    bundle   = '0;
    case (op)
      OP_NOP:  ;
      OP_ADD:  begin bundle.EXE_CMD = EXE_ADD;  bundle.WB_EN = 1'b1; end
      OP_SUB:  begin bundle.EXE_CMD = EXE_SUB;  bundle.WB_EN = 1'b1; end
      OP_AND:  begin bundle.EXE_CMD = EXE_AND;  bundle.WB_EN = 1'b1; end
      OP_OR:   begin bundle.EXE_CMD = EXE_OR;   bundle.WB_EN = 1'b1; end
      OP_NOR:  begin bundle.EXE_CMD = EXE_NOR;  bundle.WB_EN = 1'b1; end
      OP_XOR:  begin bundle.EXE_CMD = EXE_XOR;  bundle.WB_EN = 1'b1; end
      OP_SLA:  begin bundle.EXE_CMD = EXE_SLA;  bundle.WB_EN = 1'b1; end
      OP_SLL:  begin bundle.EXE_CMD = EXE_SLL;  bundle.WB_EN = 1'b1; end
      OP_SRA:  begin bundle.EXE_CMD = EXE_SRA;  bundle.WB_EN = 1'b1; end
      OP_SRL:  begin bundle.EXE_CMD = EXE_SRL;  bundle.WB_EN = 1'b1; end
      OP_SLT:  begin bundle.EXE_CMD = EXE_SLT;  bundle.WB_EN = 1'b1; end
      OP_SLTU: begin bundle.EXE_CMD = EXE_SLTU; bundle.WB_EN = 1'b1; end
      OP_ADDI: begin bundle.EXE_CMD = EXE_ADD; bundle.WB_EN = 1'b1; bundle.Is_Imm = 1'b1; end
      OP_SUBI: begin bundle.EXE_CMD = EXE_SUB; bundle.WB_EN = 1'b1; bundle.Is_Imm = 1'b1; end
      OP_ANDI: begin bundle.EXE_CMD = EXE_AND; bundle.WB_EN = 1'b1; bundle.Is_Imm = 1'b1; end
      OP_ORI:  begin bundle.EXE_CMD = EXE_OR;  bundle.WB_EN = 1'b1; bundle.Is_Imm = 1'b1; end
      OP_XORI: begin bundle.EXE_CMD = EXE_XOR; bundle.WB_EN = 1'b1; bundle.Is_Imm = 1'b1; end
      OP_SLTI: begin bundle.EXE_CMD = EXE_SLT; bundle.WB_EN = 1'b1; bundle.Is_Imm = 1'b1; end
      OP_LD: begin
        bundle.EXE_CMD  = EXE_ADD;
        bundle.Is_Imm   = 1'b1;
        bundle.WB_EN    = 1'b1;
        bundle.MEM_R_EN = 1'b1;
      end
      // Stores and two-register compares need the second source register read.
      OP_ST: begin
        bundle.EXE_CMD   = EXE_ADD;
        bundle.Is_Imm    = 1'b1;
        bundle.ST_or_BNE = 1'b1;
        bundle.MEM_W_EN  = 1'b1;
      end
      OP_BEZ: begin
        bundle.branchEn = 1'b1; bundle.Is_Imm = 1'b1; bundle.Branch_command = COND_BEZ;
      end
      OP_BNE: begin
        bundle.branchEn = 1'b1; bundle.Is_Imm = 1'b1; bundle.ST_or_BNE = 1'b1;
        bundle.Branch_command = COND_BNE;
      end
      OP_BEQ: begin
        bundle.branchEn = 1'b1; bundle.Is_Imm = 1'b1; bundle.ST_or_BNE = 1'b1;
        bundle.Branch_command = COND_BEQ;
      end
      OP_JMP: begin
        bundle.branchEn = 1'b1; bundle.Is_Imm = 1'b1; bundle.Branch_command = COND_JUMP;
      end
`ifdef CTRL_MULDIV_EN
      // MULT/DIV write HI/LO inside the unit, so only the moves back write the register file.
      OP_MULT: bundle.EXE_CMD = EXE_MULT;
      OP_DIV:  bundle.EXE_CMD = EXE_DIV;
      OP_MFHI: begin bundle.EXE_CMD = EXE_MFHI; bundle.WB_EN = 1'b1; end
      OP_MFLO: begin bundle.EXE_CMD = EXE_MFLO; bundle.WB_EN = 1'b1; end
`endif
      default: bundle.illegal_op = 1'b1;
    endcase
    if (!in_range) begin
      bundle            = '0;
      bundle.illegal_op = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage
// Registers the decoded control bundle into the ID/EX boundary, inserting
// bubbles for flush, load-use hazards and MULT/DIV structural stalls, and
// sequences the multi-cycle MULT/DIV unit.
// Configuration: CTRL_MULDIV_EN enables the MULT/DIV sequencer; without it
// md_busy and stall_out are tied low.
// Ports:
//   clk, rst            clock, async active-high reset
//   opCode, valid_in    ID-stage instruction
//   hazard_detected     load-use bubble request
//   flush               kill current ID instruction
//   stall_out           comb; hold PC and IF/ID
//   valid_out, controls registered ID/EX bundle
//   illegal_op          registered; undefined opcode accepted
//   md_busy             registered; MULT/DIV unit occupied
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int OP_CODE_LEN = 6,
  parameter int EXE_CMD_LEN = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_CODE_LEN-1:0] opCode,
  input  logic                   valid_in,
  input  logic                   hazard_detected,
  input  logic                   flush,
  output logic                   stall_out,
  output logic                   valid_out,
  output logic                   branchEn,
  output logic                   Is_Imm,
  output logic                   ST_or_BNE,
  output logic                   WB_EN,
  output logic                   MEM_R_EN,
  output logic                   MEM_W_EN,
  output logic [EXE_CMD_LEN-1:0] EXE_CMD,
  output logic [3:0]             Branch_command,
  output logic                   illegal_op,
  output logic                   md_busy
);

  ctrl_bundle_t dec_bundle;
  ctrl_bundle_t bundle_q;
  logic         valid_q;
  logic         accept;

  ctrl_decoder #(.OP_CODE_LEN(OP_CODE_LEN)) u_decoder (
    .op_code (opCode),
    .bundle  (dec_bundle)
  );

`ifdef CTRL_MULDIV_EN
  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX) + 1;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_mult, is_div, md_class;

  assign is_mult  = (opCode == OP_CODE_LEN'(OP_MULT));
  assign is_div   = (opCode == OP_CODE_LEN'(OP_DIV));
  assign md_class = is_mult | is_div
                  | (opCode == OP_CODE_LEN'(OP_MFHI))
                  | (opCode == OP_CODE_LEN'(OP_MFLO));

  assign md_busy   = (state_q == MD_BUSY);
  assign stall_out = valid_in & md_class & md_busy & ~flush;
  assign accept    = valid_in & ~flush & ~hazard_detected & ~stall_out;

  // Sequencer: an accepted MULT/DIV loads its occupancy, and the unit frees
  // itself on the cycle the count reaches 1. flush does not touch it because
  // the operation was already committed when it was accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (accept && (is_mult || is_div)) begin
          state_d = MD_BUSY;
          cnt_d   = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign md_busy   = 1'b0;
  assign stall_out = 1'b0;
  assign accept    = valid_in & ~flush & ~hazard_detected;
`endif

  // ID/EX control register: either the decoded instruction or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      bundle_q <= dec_bundle;
    end else begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end
  end

  assign valid_out      = valid_q;
  assign branchEn       = bundle_q.branchEn;
  assign Is_Imm         = bundle_q.Is_Imm;
  assign ST_or_BNE      = bundle_q.ST_or_BNE;
  assign WB_EN          = bundle_q.WB_EN;
  assign MEM_R_EN       = bundle_q.MEM_R_EN;
  assign MEM_W_EN       = bundle_q.MEM_W_EN;
  assign EXE_CMD        = EXE_CMD_LEN'(bundle_q.EXE_CMD);
  assign Branch_command = bundle_q.Branch_command;
  assign illegal_op     = bundle_q.illegal_op;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage
// Randomized and directed stimulus against a behavioural model of the
// control stage: an opcode rule table plus a single "cycles remaining"
// counter for the MULT/DIV unit.
module tb_ctrl_decode_stage;
  import ctrl_pkg::*;

  localparam int MC = 4;
  localparam int DC = 32;
`ifdef CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opCode;
  logic       valid_in, hazard_detected, flush;
  logic       stall_out, valid_out, branchEn, Is_Imm, ST_or_BNE, WB_EN;
  logic       MEM_R_EN, MEM_W_EN, illegal_op, md_busy;
  logic [3:0] EXE_CMD, Branch_command;

  int checks = 0;
  int errors = 0;

  ctrl_bundle_t m_bundle;
  logic         m_valid;
  int           m_remain;

  ctrl_decode_stage #(
    .OP_CODE_LEN(6), .EXE_CMD_LEN(4), .MULT_CYCLES(MC), .DIV_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .valid_in(valid_in),
    .hazard_detected(hazard_detected), .flush(flush), .stall_out(stall_out),
    .valid_out(valid_out), .branchEn(branchEn), .Is_Imm(Is_Imm),
    .ST_or_BNE(ST_or_BNE), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .EXE_CMD(EXE_CMD), .Branch_command(Branch_command),
    .illegal_op(illegal_op), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic ctrl_bundle_t dutBundle();
    ctrl_bundle_t b;
    b.branchEn       = branchEn;
    b.EXE_CMD        = EXE_CMD;
    b.Branch_command = Branch_command;
    b.Is_Imm         = Is_Imm;
    b.ST_or_BNE      = ST_or_BNE;
    b.WB_EN          = WB_EN;
    b.MEM_R_EN       = MEM_R_EN;
    b.MEM_W_EN       = MEM_W_EN;
    b.illegal_op     = illegal_op;
    return b;
  endfunction

  // Reference decode, organised by instruction class.
  function automatic ctrl_bundle_t refDecode(input logic [5:0] op);
    ctrl_bundle_t b;
    logic [3:0]   cmd;
    bit           reg_alu, imm_alu;
    b       = '0;
    reg_alu = 1'b1;
    imm_alu = 1'b0;
    cmd     = 4'd0;
    case (op)
      OP_ADD:  cmd = EXE_ADD;   OP_SUB:  cmd = EXE_SUB;
      OP_AND:  cmd = EXE_AND;   OP_OR:   cmd = EXE_OR;
      OP_NOR:  cmd = EXE_NOR;   OP_XOR:  cmd = EXE_XOR;
      OP_SLA:  cmd = EXE_SLA;   OP_SLL:  cmd = EXE_SLL;
      OP_SRA:  cmd = EXE_SRA;   OP_SRL:  cmd = EXE_SRL;
      OP_SLT:  cmd = EXE_SLT;   OP_SLTU: cmd = EXE_SLTU;
      default: reg_alu = 1'b0;
    endcase
    case (op)
      OP_ADDI: begin imm_alu = 1'b1; cmd = EXE_ADD; end
      OP_SUBI: begin imm_alu = 1'b1; cmd = EXE_SUB; end
      OP_ANDI: begin imm_alu = 1'b1; cmd = EXE_AND; end
      OP_ORI:  begin imm_alu = 1'b1; cmd = EXE_OR;  end
      OP_XORI: begin imm_alu = 1'b1; cmd = EXE_XOR; end
      OP_SLTI: begin imm_alu = 1'b1; cmd = EXE_SLT; end
      default: ;
    endcase
    if (reg_alu || imm_alu) begin
      b.EXE_CMD = cmd;
      b.WB_EN   = 1'b1;
      b.Is_Imm  = imm_alu;
    end else if (op == OP_LD || op == OP_ST) begin
      b.EXE_CMD   = EXE_ADD;
      b.Is_Imm    = 1'b1;
      b.WB_EN     = (op == OP_LD);
      b.MEM_R_EN  = (op == OP_LD);
      b.MEM_W_EN  = (op == OP_ST);
      b.ST_or_BNE = (op == OP_ST);
    end else if (op == OP_BEZ || op == OP_BNE || op == OP_BEQ || op == OP_JMP) begin
      b.branchEn  = 1'b1;
      b.Is_Imm    = 1'b1;
      b.ST_or_BNE = (op == OP_BNE || op == OP_BEQ);
      b.Branch_command = (op == OP_BEZ) ? COND_BEZ : (op == OP_BNE) ? COND_BNE :
                         (op == OP_BEQ) ? COND_BEQ : COND_JUMP;
    end else if (MD_EN && (op == OP_MULT || op == OP_DIV)) begin
      b.EXE_CMD = (op == OP_MULT) ? EXE_MULT : EXE_DIV;
    end else if (MD_EN && (op == OP_MFHI || op == OP_MFLO)) begin
      b.EXE_CMD = (op == OP_MFHI) ? EXE_MFHI : EXE_MFLO;
      b.WB_EN   = 1'b1;
    end else if (op != OP_NOP) begin
      b.illegal_op = 1'b1;
    end
    return b;
  endfunction

  // Drives one cycle just after a rising edge, checks the combinational stall,
  // advances the model across the edge and checks the registered outputs.
  task automatic applyStimulus(input logic [5:0] op, input logic v, input logic haz,
                               input logic fl, output logic seen_stall);
    bit is_md, is_start, exp_stall, accepted;
    opCode = op; valid_in = v; hazard_detected = haz; flush = fl;
    #1;
    is_md     = MD_EN && (op == OP_MULT || op == OP_DIV || op == OP_MFHI || op == OP_MFLO);
    is_start  = MD_EN && (op == OP_MULT || op == OP_DIV);
    exp_stall = v && is_md && (m_remain > 0) && !fl;
    seen_stall = stall_out;
    checkOutput("stall_out", stall_out, exp_stall);
    accepted = v && !fl && !haz && !exp_stall;
    if (m_remain > 0) m_remain--;
    if (accepted && is_start) m_remain = (op == OP_MULT) ? MC : DC;
    m_valid  = accepted;
    m_bundle = accepted ? refDecode(op) : '0;
    @(posedge clk);
    #1;
    checkOutput("valid_out", valid_out, m_valid);
    checkOutput("bundle", dutBundle(), m_bundle);
    checkOutput("md_busy", md_busy, m_remain > 0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    #1;
    m_remain = 0; m_valid = 1'b0; m_bundle = '0;
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_bundle", dutBundle(), 0);
    checkOutput("rst_md_busy", md_busy, 0);
    checkOutput("rst_stall", stall_out, 0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic s;
    int   stalls;
    logic [5:0] op;
    rst = 1'b0; opCode = '0; valid_in = 1'b0; hazard_detected = 1'b0; flush = 1'b0;
    m_remain = 0; m_valid = 1'b0; m_bundle = '0;
    @(posedge clk); #1;
    applyReset();

    // ADD, ADDI, XORI back to back.
    applyStimulus(OP_ADD, 1, 0, 0, s);
    checkOutput("add_cmd", EXE_CMD, EXE_ADD);
    checkOutput("add_wb", WB_EN, 1);
    applyStimulus(OP_ADDI, 1, 0, 0, s);
    checkOutput("addi_imm", Is_Imm, 1);
    applyStimulus(OP_XORI, 1, 0, 0, s);
    checkOutput("xori_cmd", EXE_CMD, EXE_XOR);
    checkOutput("xori_imm", Is_Imm, 1);

    // Load-use bubble, then hazard together with flush.
    applyStimulus(OP_LD, 1, 1, 0, s);
    checkOutput("ld_haz_memr", MEM_R_EN, 0);
    applyStimulus(OP_LD, 1, 1, 1, s);
    checkOutput("haz_flush_valid", valid_out, 0);

    // MULT immediately followed by a held MFLO.
    applyStimulus(OP_MULT, 1, 0, 0, s);
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(OP_MFLO, 1, 0, 0, s);
      if (s) stalls++;
      else break;
    end
    checkOutput("mflo_stalls", stalls, MD_EN ? MC : 0);
    checkOutput("mflo_wb", WB_EN, MD_EN);

    // Independent work is not held behind the unit.
    applyStimulus(OP_MULT, 1, 0, 0, s);
    applyStimulus(OP_ADD, 1, 0, 0, s);
    checkOutput("add_during_mult", valid_out, 1);

    // Let the MULT drain, then DIV; a flushed BEQ must not disturb the DIV.
    for (int i = 0; i < MC; i++) applyStimulus(OP_NOP, 0, 0, 0, s);
    applyStimulus(OP_DIV, 1, 0, 0, s);
    checkOutput("div_illegal", illegal_op, !MD_EN);
    applyStimulus(OP_BEQ, 1, 0, 1, s);
    checkOutput("beq_flush_br", branchEn, 0);
    checkOutput("div_busy_after_flush", md_busy, MD_EN);
    for (int i = 0; i < 3; i++) applyStimulus(OP_NOP, 0, 0, 0, s);

    // Reset in the fifth busy cycle of the DIV, then a MULT goes straight in.
    applyReset();
    applyStimulus(OP_MULT, 1, 0, 0, s);
    checkOutput("mult_after_rst_stall", s, 0);
    checkOutput("mult_after_rst_valid", valid_out, 1);
    for (int i = 0; i < MC; i++) applyStimulus(OP_NOP, 0, 0, 0, s);

    // Undefined opcode.
    applyStimulus(6'd63, 1, 0, 0, s);
    checkOutput("undef_illegal", illegal_op, 1);
    checkOutput("undef_wb", WB_EN, 0);

    // Randomized traffic, biased toward MULT/DIV-class opcodes.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0: op = OP_MULT;
        1: op = OP_MFLO;
        2: op = ($urandom_range(0, 3) == 0) ? OP_DIV : OP_MFHI;
        default: op = 6'($urandom_range(0, 63));
      endcase
      applyStimulus(op, ($urandom_range(0, 9) < 8), ($urandom_range(0, 6) == 0),
                    ($urandom_range(0, 9) == 0), s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
